// File: rtl/frame_pkg.sv
// Shared frame constants and FSM state encoding for the price/amount framer.
package frame_pkg;

   localparam logic [7:0] FLAG          = 8'h7E;
   localparam logic [7:0] ESC           = 8'h7D;
   localparam logic [7:0] ESC_XOR       = 8'h20;
   localparam int         PAYLOAD_BYTES = 8;

   // One-hot so it lines up with the receiver's state decode.
   typedef enum logic [4:0] {
      IDLE = 5'b00001,
      SOF  = 5'b00010,
      DATA = 5'b00100,
      ESC2 = 5'b01000,
      EOF  = 5'b10000
   } state_t;

endpackage

// File: rtl/frame_esc_unit.sv
// Byte-stuffing lookup: tells the framer whether a payload byte collides with
// the flag or escape code and supplies the XOR-ed second byte of the escape.
import frame_pkg::*;

module frame_esc_unit (
   input  logic [7:0] i_byte,
   output logic       o_needsEscape,
   output logic [7:0] o_escapedByte
);

   // Only the two reserved codes are stuffed; everything else, 0x7F included, passes raw.
   always_comb begin
      o_needsEscape = (i_byte == FLAG) || (i_byte == ESC);
      o_escapedByte = i_byte ^ ESC_XOR;
   end

endmodule

// File: rtl/frame_pack.sv
// Packs a 32-bit price and 32-bit amount into a flag-delimited, byte-stuffed
// frame and streams it to a UART transmitter over a valid/ready handshake.
import frame_pkg::*;

module frame_pack (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] price,
   input  logic [31:0] amount,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);

   state_t      r_state;
   state_t      w_nextState;
   logic [63:0] r_buf;
   logic [2:0]  r_idx;
   logic [7:0]  r_txData;
   logic        r_txValid;
   logic        r_done;

   logic [2:0]  w_nextIdx;
   logic [7:0]  w_nextTxData;
   logic        w_nextTxValid;
   logic        w_nextDone;
   logic        w_loadBuf;
   logic        w_xfer;

   logic [2:0]  w_mapIdx;
   logic [5:0]  w_bitBase;
   logic [7:0]  w_mapByte;
   logic        w_needsEscape;
   logic [7:0]  w_escapedByte;

   assign w_xfer    = r_txValid && tx_ready;
   assign w_bitBase = {~w_mapIdx, 3'b000};
   assign w_mapByte = r_buf[w_bitBase +: 8];

   assign in_ready  = (r_state == IDLE);
   assign tx_data   = r_txData;
   assign tx_valid  = r_txValid;
   assign done      = r_done;

   frame_esc_unit u_esc (
      .i_byte        (w_mapByte),
      .o_needsEscape (w_needsEscape),
      .o_escapedByte (w_escapedByte)
   );

   // State register; reset drops straight back to IDLE, abandoning any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and next-byte selection. While a byte is stalled nothing changes.
   // A plain payload byte can never equal ESC, so tx_data == ESC in DATA means the
   // escape prefix is on the wire and the XOR byte of the same index comes next;
   // otherwise the escape unit looks one byte ahead.
   always_comb begin
      w_nextState   = r_state;
      w_nextIdx     = r_idx;
      w_nextTxData  = r_txData;
      w_nextTxValid = r_txValid;
      w_nextDone    = 1'b0;
      w_loadBuf     = 1'b0;
      w_mapIdx      = r_idx;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_loadBuf     = 1'b1;
               w_nextState   = SOF;
               w_nextIdx     = 3'd0;
               w_nextTxData  = FLAG;
               w_nextTxValid = 1'b1;
            end
         end
         SOF: begin
            w_mapIdx = r_idx;
            if (w_xfer) begin
               w_nextState  = DATA;
               w_nextTxData = w_needsEscape ? ESC : w_mapByte;
            end
         end
         DATA: begin
            if (r_txData == ESC) begin
               w_mapIdx = r_idx;
               if (w_xfer) begin
                  w_nextState  = ESC2;
                  w_nextTxData = w_escapedByte;
               end
            end else begin
               w_mapIdx = r_idx + 3'd1;
               if (w_xfer) begin
                  w_nextIdx = r_idx + 3'd1;
                  if (r_idx == 3'(PAYLOAD_BYTES - 1)) begin
                     w_nextState  = EOF;
                     w_nextTxData = FLAG;
                  end else begin
                     w_nextTxData = w_needsEscape ? ESC : w_mapByte;
                  end
               end
            end
         end
         ESC2: begin
            w_mapIdx = r_idx + 3'd1;
            if (w_xfer) begin
               w_nextIdx = r_idx + 3'd1;
               if (r_idx == 3'(PAYLOAD_BYTES - 1)) begin
                  w_nextState  = EOF;
                  w_nextTxData = FLAG;
               end else begin
                  w_nextState  = DATA;
                  w_nextTxData = w_needsEscape ? ESC : w_mapByte;
               end
            end
         end
         EOF: begin
            if (w_xfer) begin
               w_nextState   = IDLE;
               w_nextTxData  = 8'h00;
               w_nextTxValid = 1'b0;
               w_nextDone    = 1'b1;
            end
         end
         default: begin
            w_nextState   = IDLE;
            w_nextTxData  = 8'h00;
            w_nextTxValid = 1'b0;
         end
      endcase
   end

   // Datapath registers: captured payload, byte index and the registered tx outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf     <= 64'd0;
         r_idx     <= 3'd0;
         r_txData  <= 8'h00;
         r_txValid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_loadBuf) begin
            r_buf <= {price, amount};
         end
         r_idx     <= w_nextIdx;
         r_txData  <= w_nextTxData;
         r_txValid <= w_nextTxValid;
         r_done    <= w_nextDone;
      end
   end

endmodule

// File: tb/tb_frame_pack.sv
// Self-checking bench for frame_pack: a reference framer fills a byte scoreboard,
// a monitor pops it on every transfer and also unstuffs the stream back into
// price/amount to compare against what was sent.
module tb_frame_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] price;
   logic [31:0] amount;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        done;

   int testsRun    = 0;
   int testsFailed = 0;
   int doneCount   = 0;
   bit randReady   = 1'b0;

   logic [7:0]  byteQ[$];
   logic [63:0] frameQ[$];

   bit          holdPrev = 1'b0;
   logic [7:0]  holdData = 8'h00;
   bit          prevDone = 1'b0;
   bit          decEsc   = 1'b0;
   int          decCount = 0;
   logic [63:0] decWord  = 64'd0;

   frame_pack dut (
      .clk      (clk),
      .rst      (rst),
      .price    (price),
      .amount   (amount),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .done     (done)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference framer: flag, eight stuffed payload bytes MSB first, flag.
   function automatic void pushFrame(input logic [31:0] p, input logic [31:0] a);
      logic [63:0] word;
      logic [7:0]  b;
      word = {p, a};
      byteQ.push_back(8'h7E);
      for (int i = 0; i < 8; i++) begin
         b = word[63 - 8*i -: 8];
         if (b == 8'h7E || b == 8'h7D) begin
            byteQ.push_back(8'h7D);
            byteQ.push_back(b ^ 8'h20);
         end else begin
            byteQ.push_back(b);
         end
      end
      byteQ.push_back(8'h7E);
      frameQ.push_back(word);
   endfunction

   // Monitor on the falling edge: scoreboard pop, hold-stability, done pulse and loopback decode.
   always @(negedge clk) begin
      logic [7:0] expByte;
      logic [7:0] b;
      if (rst) begin
         holdPrev = 1'b0;
         prevDone = 1'b0;
         decEsc   = 1'b0;
         decCount = 0;
      end else begin
         if (holdPrev) begin
            checkOutput("holdData", {56'd0, tx_data}, {56'd0, holdData});
            checkOutput("holdValid", {63'd0, tx_valid}, 64'd1);
         end
         holdPrev = tx_valid && !tx_ready;
         holdData = tx_data;
         if (done) begin
            doneCount++;
            checkOutput("doneReady", {63'd0, in_ready}, 64'd1);
            checkOutput("doneWidth", {63'd0, prevDone}, 64'd0);
         end
         prevDone = done;
         if (tx_valid && tx_ready) begin
            if (byteQ.size() == 0) begin
               checkOutput("unexpectedByte", {56'd0, tx_data}, 64'h100);
            end else begin
               expByte = byteQ.pop_front();
               checkOutput("txByte", {56'd0, tx_data}, {56'd0, expByte});
            end
            if (tx_data == 8'h7E) begin
               if (decCount == 8) begin
                  if (frameQ.size() == 0) begin
                     checkOutput("loopbackExtra", decWord, 64'd0 - 64'd1);
                  end else begin
                     checkOutput("loopback", decWord, frameQ.pop_front());
                  end
               end
               decCount = 0;
               decEsc   = 1'b0;
            end else if (tx_data == 8'h7D) begin
               decEsc = 1'b1;
            end else begin
               b        = decEsc ? (tx_data ^ 8'h20) : tx_data;
               decWord  = {decWord[55:0], b};
               decCount++;
               decEsc   = 1'b0;
            end
         end
      end
   end

   // Pseudo-random transmitter readiness while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) tx_ready = 1'($urandom_range(0, 1));
      end
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Presents one frame for a single cycle; called just after a rising edge with in_ready high.
   task automatic applyStimulus(input logic [31:0] p, input logic [31:0] a);
      checkOutput("readyBeforeAccept", {63'd0, in_ready}, 64'd1);
      price    = p;
      amount   = a;
      in_valid = 1'b1;
      pushFrame(p, a);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      price    = $urandom;
      amount   = $urandom;
      checkOutput("sofValid", {63'd0, tx_valid}, 64'd1);
      checkOutput("sofData", {56'd0, tx_data}, 64'h7E);
      checkOutput("busyReady", {63'd0, in_ready}, 64'd0);
   endtask

   // Waits for done with a cycle budget, optionally poking in_valid mid-frame.
   task automatic waitDone(input int maxCycles, input bit pulseMid, output int cycles);
      cycles = 0;
      while (!done && cycles < maxCycles) begin
         if (pulseMid && cycles == 3) begin
            checkOutput("midReady", {63'd0, in_ready}, 64'd0);
            price    = 32'hFFFF_FFFF;
            amount   = 32'hFFFF_FFFF;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         cycles++;
      end
      if (!done) checkOutput("doneTimeout", {63'd0, done}, 64'd1);
   endtask

   initial begin
      int cycles;
      rst      = 1'b1;
      in_valid = 1'b0;
      price    = 32'd0;
      amount   = 32'd0;
      tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstValid", {63'd0, tx_valid}, 64'd0);
      checkOutput("rstData", {56'd0, tx_data}, 64'd0);
      checkOutput("rstReady", {63'd0, in_ready}, 64'd1);
      checkOutput("rstDone", {63'd0, done}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Plain frame, then back-to-back escaped, worst-case and raw 0x7F frames.
      applyStimulus(32'h0000_0064, 32'h0000_0003);
      waitDone(50, 1'b0, cycles);
      checkOutput("lenPlain", 64'(cycles), 64'd10);
      applyStimulus(32'h7E7D_0001, 32'h0000_0000);
      waitDone(50, 1'b0, cycles);
      checkOutput("lenEscape", 64'(cycles), 64'd12);
      applyStimulus(32'h7E7E_7E7E, 32'h7E7E_7E7E);
      waitDone(50, 1'b0, cycles);
      checkOutput("lenWorst", 64'(cycles), 64'd18);
      applyStimulus(32'h7F00_0000, 32'h0000_0000);
      waitDone(50, 1'b0, cycles);
      checkOutput("len7F", 64'(cycles), 64'd10);

      // Backpressure with a stray in_valid pulse mid-frame.
      randReady = 1'b1;
      applyStimulus(32'h7E7D_0001, 32'h0000_0000);
      waitDone(500, 1'b1, cycles);
      randReady = 1'b0;
      tx_ready  = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idleValid", {63'd0, tx_valid}, 64'd0);
      checkOutput("doneCount", 64'(doneCount), 64'd5);

      // Reset after four transferred bytes abandons the frame asynchronously.
      applyStimulus(32'h1122_3344, 32'h5566_7788);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncValid", {63'd0, tx_valid}, 64'd0);
      checkOutput("asyncReady", {63'd0, in_ready}, 64'd1);
      checkOutput("asyncData", {56'd0, tx_data}, 64'd0);
      byteQ.delete();
      frameQ.delete();
      price    = 32'h1234_5678;
      amount   = 32'h9ABC_DEF0;
      in_valid = 1'b1;
      pushFrame(32'h1234_5678, 32'h9ABC_DEF0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("firstEdgeValid", {63'd0, tx_valid}, 64'd1);
      checkOutput("firstEdgeData", {56'd0, tx_data}, 64'h7E);
      waitDone(50, 1'b0, cycles);
      checkOutput("lenAfterReset", 64'(cycles), 64'd10);
      @(posedge clk);
      #1;
      checkOutput("byteQDrained", 64'(byteQ.size()), 64'd0);
      checkOutput("frameQDrained", 64'(frameQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
